adder_4bit_lib: RTL and testbench

//  4-bit unsigned adder built as a ripple chain of library full-adder cells
//  (half/full-adder primitives instantiated, no behavioural '+').

---
 rtl/adder_4bit_lib.sv | 70 +++++++
 tb/tb_adder_4bit_lib.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_4bit_lib.sv
// 4-bit unsigned ripple adder from half/full-adder cells,
// with a combinational sum and an enable-loaded registered copy.
module adder_4bit_lib_ha (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic co
);
  assign sum = x ^ y;
  assign co  = x & y;
endmodule

module adder_4bit_lib_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);
  logic p;
  assign p   = x ^ y;
  assign sum = p ^ ci;
  assign co  = (x & y) | (ci & p);
endmodule

module adder_4bit_lib (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       en,
  output logic [4:0] s,
  output logic [4:0] s_q,
  output logic       q_valid
);
  logic [4:0] c;
  logic [3:0] sum;

  adder_4bit_lib_ha u_ha0 (
    .x   (a[0]),
    .y   (b[0]),
    .sum (sum[0]),
    .co  (c[1])
  );

  // c[0] is unused: bit 0 has no carry-in
  assign c[0] = 1'b0;

  for (genvar i = 1; i < 4; i++) begin : g_fa
    adder_4bit_lib_fa u_fa (
      .x   (a[i]),
      .y   (b[i]),
      .ci  (c[i]),
      .sum (sum[i]),
      .co  (c[i+1])
    );
  end

  assign s = {c[4], sum};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q     <= 5'h00;
      q_valid <= 1'b0;
    end else if (en) begin
      s_q     <= s;
      q_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_adder_4bit_lib.sv
// Self-checking bench for adder_4bit_lib: combinational sum
// via a scoreboard queue, plus register, enable and async reset.
module tb_adder_4bit_lib;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       en;
  logic [4:0] s;
  logic [4:0] s_q;
  logic       q_valid;

  int tests = 0;
  int fails = 0;

  logic [4:0] exp_q[$];
  logic [5:0] reg_q[$];

  adder_4bit_lib dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .en      (en),
    .s       (s),
    .s_q     (s_q),
    .q_valid (q_valid)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    reset_n = 1'b0;
    en = 1'b1;
    a = 4'h3;
    b = 4'h4;
    @(posedge clk);
    #1;
    tests++;
    if (s_q !== 5'h00 || q_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset: s_q=%h q_valid=%b want 00 0",
               s_q, q_valid);
    end
    tests++;
    if (s !== 5'h07) begin
      fails++;
      $display("FAIL reset_s: s=%h want 07", s);
    end
  endtask

  task automatic test_pairs;
    logic [3:0] ta[8];
    logic [3:0] tb[8];
    logic [4:0] te[8];
    logic [4:0] got;
    ta = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h5, 4'h8};
    tb = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'hD};
    te = '{5'h00, 5'h01, 5'h02, 5'h03,
           5'h05, 5'h08, 5'h0D, 5'h15};
    for (int i = 0; i < 8; i++) begin
      a = ta[i];
      b = tb[i];
      exp_q.push_back(te[i]);
      #100;
      got = exp_q.pop_front();
      tests++;
      if (s !== got) begin
        fails++;
        $display("FAIL pair %h+%h: s=%h want %h",
                 ta[i], tb[i], s, got);
      end
    end
  endtask

  task automatic test_carry;
    logic [3:0] ta[3];
    logic [3:0] tb[3];
    logic [4:0] te[3];
    logic [4:0] got;
    ta = '{4'hF, 4'hF, 4'h7};
    tb = '{4'h1, 4'hF, 4'h8};
    te = '{5'h10, 5'h1E, 5'h0F};
    for (int i = 0; i < 3; i++) begin
      a = ta[i];
      b = tb[i];
      exp_q.push_back(te[i]);
      #10;
      got = exp_q.pop_front();
      tests++;
      if (s !== got) begin
        fails++;
        $display("FAIL carry %h+%h: s=%h want %h",
                 ta[i], tb[i], s, got);
      end
    end
  endtask

  task automatic test_exhaustive;
    logic [4:0] got;
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 4'(i);
        b = 4'(j);
        exp_q.push_back(5'(i + j));
        #2;
        got = exp_q.pop_front();
        tests++;
        if (s !== got) begin
          fails++;
          bad++;
          if (bad <= 8)
            $display("FAIL exh %0d+%0d: s=%h want %h",
                     i, j, s, got);
        end
      end
    end
  endtask

  task automatic test_register;
    logic [5:0] got;
    @(negedge clk);
    en = 1'b0;
    reset_n = 1'b1;
    a = 4'h2;
    b = 4'h2;
    reg_q.push_back({1'b0, 5'h00});
    @(posedge clk);
    #1;
    got = reg_q.pop_front();
    tests++;
    if ({q_valid, s_q} !== got) begin
      fails++;
      $display("FAIL reg_noen: q=%b s_q=%h want %b %h",
               q_valid, s_q, got[5], got[4:0]);
    end
    @(negedge clk);
    a = 4'h5;
    b = 4'h8;
    en = 1'b1;
    reg_q.push_back({1'b1, 5'h0D});
    @(posedge clk);
    #1;
    got = reg_q.pop_front();
    tests++;
    if ({q_valid, s_q} !== got) begin
      fails++;
      $display("FAIL reg_cap: q=%b s_q=%h want %b %h",
               q_valid, s_q, got[5], got[4:0]);
    end
    @(negedge clk);
    en = 1'b0;
    a = 4'h1;
    reg_q.push_back({1'b1, 5'h0D});
    @(posedge clk);
    #1;
    got = reg_q.pop_front();
    tests++;
    if ({q_valid, s_q} !== got) begin
      fails++;
      $display("FAIL reg_hold: q=%b s_q=%h want %b %h",
               q_valid, s_q, got[5], got[4:0]);
    end
    tests++;
    if (s !== 5'h09) begin
      fails++;
      $display("FAIL reg_s: s=%h want 09", s);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] got;
    logic [3:0] x;
    logic [3:0] y;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      a = x;
      b = y;
      reg_q.push_back({1'b1, 5'({1'b0, x} + {1'b0, y})});
      @(posedge clk);
      #1;
      got = reg_q.pop_front();
      tests++;
      if ({q_valid, s_q} !== got) begin
        fails++;
        $display("FAIL b2b %h+%h: s_q=%h want %h",
                 x, y, s_q, got[4:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    a = 4'hA;
    b = 4'h3;
    en = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (s_q !== 5'h0D || q_valid !== 1'b1) begin
      fails++;
      $display("FAIL async_pre: s_q=%h q=%b want 0D 1",
               s_q, q_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (s_q !== 5'h00 || q_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: s_q=%h q=%b want 00 0",
               s_q, q_valid);
    end
    a = 4'h9;
    b = 4'h9;
    #1;
    tests++;
    if (s !== 5'h12) begin
      fails++;
      $display("FAIL async_s: s=%h want 12", s);
    end
    @(posedge clk);
    #1;
    tests++;
    if (s_q !== 5'h00 || q_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_hold: s_q=%h q=%b want 00 0",
               s_q, q_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    a = 4'hC;
    b = 4'h6;
    @(posedge clk);
    #1;
    tests++;
    if (s_q !== 5'h12 || q_valid !== 1'b1) begin
      fails++;
      $display("FAIL async_rel: s_q=%h q=%b want 12 1",
               s_q, q_valid);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    a = 4'h0;
    b = 4'h0;
    test_reset();
    test_pairs();
    test_carry();
    test_exhaustive();
    test_register();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
